// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver. One byte is captured per
// rising edge of rxDone. Framing-error bytes and bytes arriving while the FIFO
// is full are dropped and reported through sticky flags. The head entry is
// shown ahead on outData, and a pop happens on outValid && outReady.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxDone,
  input  logic                   rxErr,
  input  logic [7:0]             rxByte,
  output logic [7:0]             outData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overrun,
  output logic                   frameErr,
  input  logic                   clrFlags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rx_done_q;
  logic          r_overrun;
  logic          r_frame_err;

  logic          w_capture;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_set_overrun;
  logic          w_set_frame_err;
  logic [CW-1:0] w_count_nxt;

  // A level rxDone can stay high for many cycles, so only its rising edge captures a byte.
  assign w_capture       = rxDone && !r_rx_done_q;
  assign w_full          = (r_count == DEPTH_C);
  assign w_pop           = outValid && outReady;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
  assign w_push          = w_capture && !rxErr && (!w_full || w_pop);
  assign w_set_frame_err = w_capture && rxErr;
  assign w_set_overrun   = w_capture && !rxErr && w_full && !w_pop;

  // Select the next occupancy from the push and pop events.
  // NOTE: always_comb assigns a default first, so no path leaves w_count_nxt unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and the rxDone edge detector.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_done_q <= 1'b1;
    end else begin
      r_rx_done_q <= rxDone;
      r_count     <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Byte storage write port.
  // NOTE: the storage array has no reset; an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rxByte;
  end

  // Sticky error flags; a set condition wins over clrFlags in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_set_overrun)        r_overrun <= 1'b1;
      else if (clrFlags)        r_overrun <= 1'b0;
      if (w_set_frame_err)      r_frame_err <= 1'b1;
      else if (clrFlags)        r_frame_err <= 1'b0;
    end
  end

  assign outData  = r_mem[r_rd_ptr];
  assign outValid = (r_count != '0);
  assign count    = r_count;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign frameErr = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed tests for uart_rx_fifo with DEPTH=16. Inputs are
// driven on the falling clock edge, and outputs are sampled on the falling edge
// after the rising edge that updates them.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxByte;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       frameErr;
  logic       clrFlags;

  int n_tests;
  int n_fail;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxDone   (rxDone),
    .rxErr    (rxErr),
    .rxByte   (rxByte),
    .outData  (outData),
    .outValid (outValid),
    .outReady (outReady),
    .count    (count),
    .full     (full),
    .overrun  (overrun),
    .frameErr (frameErr),
    .clrFlags (clrFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one byte: rxDone goes high for hold cycles, then low for one cycle.
  task automatic rx_byte(input logic [7:0] b, input logic e, input int hold);
    rxByte = b;
    rxErr  = e;
    rxDone = 1'b1;
    repeat (hold) @(negedge clk);
    rxDone = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxDone = 1'b0; rxErr = 1'b0; rxByte = 8'h00;
    outReady = 1'b0; clrFlags = 1'b0;
    #12;
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if (outValid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", outValid); end
    n_tests++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_tests++; if (frameErr !== 1'b0)  begin n_fail++; $display("FAIL reset_frameErr: got %b expected 0", frameErr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    rx_byte(8'h56, 1'b0, 50);
    n_tests++; if (count !== 5'd1)     begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end
    n_tests++; if (outValid !== 1'b1)  begin n_fail++; $display("FAIL single_valid: got %b expected 1", outValid); end
    n_tests++; if (outData !== 8'h56)  begin n_fail++; $display("FAIL single_data: got %h expected 56", outData); end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL single_pop_count: got %0d expected 0", count); end
    n_tests++; if (outValid !== 1'b0)  begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", outValid); end
  endtask

  task automatic test_frame_err();
    rx_byte(8'hAA, 1'b1, 3);
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL ferr_count: got %0d expected 0", count); end
    n_tests++; if (frameErr !== 1'b1)  begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frameErr); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL ferr_overrun: got %b expected 0", overrun); end
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    n_tests++; if (frameErr !== 1'b0)  begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", frameErr); end
    // Capture with rxErr and clrFlags in the same cycle: the set wins.
    rxByte = 8'h3C; rxErr = 1'b1; rxDone = 1'b1; clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0; rxDone = 1'b0;
    @(negedge clk);
    n_tests++; if (frameErr !== 1'b1)  begin n_fail++; $display("FAIL ferr_set_wins: got %b expected 1", frameErr); end
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0; rxErr = 1'b0;
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) rx_byte(8'(i), 1'b0, 2);
    n_tests++; if (count !== 5'd16)    begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
    n_tests++; if (full !== 1'b1)      begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL fill_no_overrun: got %b expected 0", overrun); end
    rx_byte(8'h10, 1'b0, 2);
    n_tests++; if (overrun !== 1'b1)   begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    n_tests++; if (count !== 5'd16)    begin n_fail++; $display("FAIL overrun_count: got %0d expected 16", count); end
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (outValid !== 1'b1 || outData !== 8'(i)) begin
        n_fail++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, outValid, outData, 8'(i));
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
    end
    n_tests++; if (outValid !== 1'b0)  begin n_fail++; $display("FAIL drain_empty: got %b expected 0", outValid); end
    // outReady on an empty FIFO must not underflow the count.
    outReady = 1'b1;
    repeat (2) @(negedge clk);
    outReady = 1'b0;
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL empty_ready: got %0d expected 0", count); end
    clrFlags = 1'b1;
    @(negedge clk);
    clrFlags = 1'b0;
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) rx_byte(8'(i), 1'b0, 2);
    // Capture 8'h10 in the same cycle as a pop from the full FIFO.
    rxByte = 8'h10; rxErr = 1'b0; rxDone = 1'b1; outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0; rxDone = 1'b0;
    @(negedge clk);
    n_tests++; if (count !== 5'd16)    begin n_fail++; $display("FAIL fullpop_count: got %0d expected 16", count); end
    n_tests++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL fullpop_overrun: got %b expected 0", overrun); end
    for (int i = 1; i <= 16; i++) begin
      n_tests++;
      if (outValid !== 1'b1 || outData !== 8'(i)) begin
        n_fail++; $display("FAIL fullpop_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, outValid, outData, 8'(i));
      end
      outReady = 1'b1;
      @(negedge clk);
      outReady = 1'b0;
    end
    n_tests++; if (outValid !== 1'b0)  begin n_fail++; $display("FAIL fullpop_empty: got %b expected 0", outValid); end
  endtask

  task automatic test_wrap();
    int         sent  = 0;
    int         got   = 0;
    int         phase = 0;
    int         cyc   = 0;
    logic       over  = 1'b0;
    logic [7:0] tx_b  = 8'h40;
    logic [7:0] exp_b = 8'h40;
    while (got < 40 && cyc < 2000) begin
      if (sent < 40) begin
        case (phase)
          0: begin rxByte = tx_b; rxErr = 1'b0; rxDone = 1'b1; phase = 1; end
          1: phase = 2;
          default: begin rxDone = 1'b0; phase = 0; sent++; tx_b = tx_b + 8'd1; end
        endcase
      end
      outReady = 1'($urandom_range(0, 1));
      if (outValid && outReady) begin
        n_tests++;
        if (outData !== exp_b) begin
          n_fail++; $display("FAIL wrap_byte_%0d: got %h expected %h", got, outData, exp_b);
        end
        exp_b = exp_b + 8'd1;
        got++;
      end
      if (count > 5'd16) over = 1'b1;
      @(negedge clk);
      cyc++;
    end
    rxDone = 1'b0; outReady = 1'b0;
    @(negedge clk);
    n_tests++; if (got != 40)          begin n_fail++; $display("FAIL wrap_timeout: got %0d bytes expected 40", got); end
    n_tests++; if (over !== 1'b0)      begin n_fail++; $display("FAIL wrap_count_max: got over=%b expected 0", over); end
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL wrap_end_count: got %0d expected 0", count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) rx_byte(8'hA0 + 8'(i), 1'b0, 2);
    n_tests++; if (count !== 5'd5)     begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 5", count); end
    rxByte = 8'h77; rxDone = 1'b1; rst_n = 1'b0;
    #1;
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL mid_async_count: got %0d expected 0", count); end
    n_tests++; if (outValid !== 1'b0)  begin n_fail++; $display("FAIL mid_async_valid: got %b expected 0", outValid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++; if (count !== 5'd0)     begin n_fail++; $display("FAIL mid_no_capture: got %0d expected 0", count); end
    rxDone = 1'b0;
    @(negedge clk);
    rxDone = 1'b1;
    @(negedge clk);
    rxDone = 1'b0;
    n_tests++; if (count !== 5'd1)     begin n_fail++; $display("FAIL mid_recapture_count: got %0d expected 1", count); end
    n_tests++; if (outData !== 8'h77)  begin n_fail++; $display("FAIL mid_recapture_data: got %h expected 77", outData); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single_byte();
    test_frame_err();
    test_fill_overrun();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL give the number of byte entries; legal values are powers of two from 2 to 256.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-004 Port rxDone, input, 1 bit, SHALL be the receiver's byte-complete indication (level; may stay high for many cycles).
REQ-005 Port rxErr, input, 1 bit, SHALL be the receiver's framing-error indication, sampled with rxDone.
REQ-006 Port rxByte, input, 8 bits, SHALL be the received byte, stable while rxDone is high.
REQ-007 Port outData, output, 8 bits, SHALL be the byte at the FIFO head (show-ahead).
REQ-008 Port outValid, output, 1 bit, SHALL be high when the FIFO is non-empty.
REQ-009 Port outReady, input, 1 bit, SHALL be the consumer's accept; a pop occurs when outValid && outReady.
REQ-010 Port count, output, $clog2(DEPTH)+1 bits, SHALL be the current occupancy, 0..DEPTH.
REQ-011 Port full, output, 1 bit, SHALL equal (count == DEPTH).
REQ-012 Port overrun, output, 1 bit, SHALL be the sticky "byte dropped, FIFO full" flag.
REQ-013 Port frameErr, output, 1 bit, SHALL be the sticky "byte dropped, rxErr set" flag.
REQ-014 Port clrFlags, input, 1 bit, SHALL clear overrun and frameErr.

Function
REQ-015 Block SHALL register rxDone into rxDoneQ and derive capture = rxDone && !rxDoneQ (one pulse per rising edge of rxDone).
REQ-016 On capture with rxErr=0 and count<DEPTH, rxByte SHALL be written at the write pointer; count +1 at the next edge.
REQ-017 On capture with rxErr=1, the byte SHALL be discarded and frameErr set at the next edge; count unchanged.
REQ-018 On capture with rxErr=0, count==DEPTH and no pop in the same cycle, the byte SHALL be discarded and overrun set; stored data unchanged.
REQ-019 On capture with rxErr=0, count==DEPTH and a pop in the same cycle, the write SHALL be accepted, count stays DEPTH, overrun not set.
REQ-020 Simultaneous accepted push and pop with 0<count<DEPTH SHALL leave count unchanged.
REQ-021 Push into an empty FIFO SHALL raise outValid with outData = pushed byte one cycle after capture (latency 1 edge from capture to visibility).
REQ-022 Pop SHALL advance the read pointer; outData SHALL show the next entry combinationally from storage in the same cycle the pointer changes.
REQ-023 outReady while outValid=0 SHALL have no effect.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-025 clrFlags SHALL clear both sticky flags at the next edge; if a set condition occurs in the same cycle, set SHALL win.
REQ-026 Flags SHALL NOT affect push/pop behaviour.

Reset
REQ-027 rst_n low SHALL immediately force count=0, pointers=0, rxDoneQ=1, overrun=0, frameErr=0, outValid=0, full=0; storage contents are don't-care.
REQ-028 rxDoneQ reset to 1 SHALL prevent a capture if rxDone is already high when rst_n deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all buffered bytes; outData is don't-care while outValid=0.

Verification
REQ-030 Single byte: rxDone rises with rxByte=8'h56, rxErr=0, held 50 cycles, outReady=0 -> count=1, outValid=1, outData=8'h56, exactly one write.
REQ-031 Framing error: rxDone rises with rxErr=1, rxByte=8'hAA -> count stays 0, frameErr=1; clrFlags pulse -> frameErr=0.
REQ-032 Fill/overrun (DEPTH=16): push 8'h00..8'h0F, then 8'h10 with outReady=0 -> full=1, overrun=1, popping yields 8'h00..8'h0F in order then outValid=0.
REQ-033 Full with simultaneous pop: full FIFO, capture 8'h10 in the cycle outReady=1 -> count stays 16, overrun=0, last popped byte is 8'h10.
REQ-034 Wrap-around: 40 push/pop pairs of incrementing bytes at random outReady duty -> output sequence equals input sequence, count never exceeds 16.
REQ-035 Reset: with count=5 and rxDone high, pulse rst_n low -> count=0, outValid=0, no capture after release until rxDone falls and rises again.
